// File: rtl/l2_seq_pkg.sv
// Shared encodings and default sizes for the layer-2 MAC sequencer.
// The SIG_* states exist only when SIGMOID_WB_EN is defined.
package l2_seq_pkg;

  localparam int N_IN_DEF  = 16;
  localparam int N_OUT_DEF = 16;
  localparam int AW_DEF    = 4;

  localparam logic GSRAM_MUX_M2  = 1'b0;
  localparam logic GSRAM_MUX_LUT = 1'b1;
  localparam logic RD_SEL_M2     = 1'b0;
  localparam logic RD_SEL_SRAM   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACC_RD   = 3'd1,
    ST_ACC_WR   = 3'd2,
    ST_DONE     = 3'd3
`ifdef SIGMOID_WB_EN
    ,
    ST_SIG_RD   = 3'd4,
    ST_SIG_WAIT = 3'd5,
    ST_SIG_WR   = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/l2_idx_counter.sv
// Nested k/c index counter: c runs 0..N_OUT-1 and carries into k, which runs 0..N_IN-1.
module l2_idx_counter
  import l2_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] k,
  output logic [AW-1:0] c,
  output logic          c_last,
  output logic          k_last
);

  assign c_last = (c == AW'(N_OUT - 1));
  assign k_last = (k == AW'(N_IN - 1));

  // Wraps come only from the explicit last-value compares, so non-power-of-two sizes work.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k <= '0;
      c <= '0;
    end else if (inc) begin
      if (c_last) begin
        c <= '0;
        k <= k_last ? '0 : k + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_mac_sequencer.sv
// Sequencer for the layer-2 read-modify-write accumulate gSRAM[out_row][c] += w2[k][c]*h[k].
// Optional sigmoid writeback pass over the output row is enabled by SIGMOID_WB_EN.
module l2_mac_sequencer
  import l2_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] out_row,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w2_addr,
  output logic          w2_load_next_row,
  output logic [AW-1:0] rd_reg_addr,
  output logic          rd_out_sel,
  output logic          mac_clr,
  output logic [AW-1:0] gsram_row,
  output logic [AW-1:0] gsram_col,
  output logic          gsram_we,
  output logic          gsram_mux
);

  state_t        state_q, state_d;
  logic [AW-1:0] row_q;
  logic [AW-1:0] k_idx, c_idx;
  logic          c_last, k_last;
  logic          cnt_clear, cnt_inc;
  logic          k_zero;

  l2_idx_counter #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .AW    (AW)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .k      (k_idx),
    .c      (c_idx),
    .c_last (c_last),
    .k_last (k_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) row_q <= out_row;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ACC_RD;
          cnt_clear = 1'b1;
        end
      end
      ST_ACC_RD: state_d = ST_ACC_WR;
      ST_ACC_WR: begin
        cnt_inc = 1'b1;
        if (c_last && k_last) begin
`ifdef SIGMOID_WB_EN
          state_d = ST_SIG_RD;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_ACC_RD;
        end
      end
`ifdef SIGMOID_WB_EN
      ST_SIG_RD:   state_d = ST_SIG_WAIT;
      ST_SIG_WAIT: state_d = ST_SIG_WR;
      ST_SIG_WR: begin
        cnt_inc = 1'b1;
        state_d = c_last ? ST_DONE : ST_SIG_RD;
      end
`endif
      ST_DONE: begin
        state_d   = ST_IDLE;
        cnt_clear = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign k_zero      = (k_idx == '0);
  assign w2_addr     = c_idx;
  assign rd_reg_addr = k_idx;
  assign gsram_col   = c_idx;
  assign gsram_row   = row_q;

  // Strobes are masked by reset so an abort never lands a write or row advance on its own edge.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    gsram_we         = 1'b0;
    gsram_mux        = GSRAM_MUX_M2;
    rd_out_sel       = RD_SEL_M2;
    mac_clr          = 1'b0;
    w2_load_next_row = 1'b0;
    case (state_q)
      ST_ACC_RD: begin
        busy    = 1'b1;
        mac_clr = k_zero;
      end
      ST_ACC_WR: begin
        busy             = 1'b1;
        mac_clr          = k_zero;
        gsram_we         = !reset;
        w2_load_next_row = c_last && !k_last && !reset;
      end
`ifdef SIGMOID_WB_EN
      ST_SIG_RD, ST_SIG_WAIT: begin
        busy       = 1'b1;
        rd_out_sel = RD_SEL_SRAM;
      end
      ST_SIG_WR: begin
        busy       = 1'b1;
        rd_out_sel = RD_SEL_SRAM;
        gsram_we   = !reset;
        gsram_mux  = GSRAM_MUX_LUT;
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
